timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  Sequencer for the team's cascaded prescaler + down-counter timer: a mod-(PRESC_MAX+1)
//  prescaler drives a CNT_W-bit down counter. Adds start/stop/pause control,
//  loadable count, one-shot/periodic modes, and tick/done pulses.
//  Sits between the control/register logic and the timing datapath; the only owner of that datapath.
// PARAMETERS
//  PRESC_W   4   prescaler width
//  PRESC_MAX 12  prescaler terminal value; prescaler period = PRESC_MAX+1 cycles (< 2**PRESC_W)
//  CNT_W     4   down-counter width
// PORTS
//  clk        in   1        sole clock; all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        load load_val and run (restart if already running)
//  stop       in   1        abort to IDLE
//  pause      in   1        level; hold the timer while high in RUN
//  periodic   in   1        1 = auto-reload at terminal count; sampled in DONE
//  load_val   in   CNT_W    initial count; sampled when start is accepted and on reload
//  count_out  out  CNT_W    current down-counter value
//  busy       out  1        state is RUN or PAUSE
//  tick       out  1        1-cycle pulse, cycle after each counter decrement
//  done       out  1        1-cycle pulse, high exactly while state==DONE
//  state_o    out  2        IDLE=0 RUN=1 PAUSE=2 DONE=3
// BEHAVIOUR
//  Reset: state IDLE; count, presc, busy, tick, done, irq (if built) all 0. rst wins over every input.
//  Input priority each edge: rst > stop > start > pause.
//  IDLE: start -> count<=load_val, presc<=0, RUN next cycle. If load_val==0 -> DONE directly.
//  RUN: presc+1 per cycle. On the edge with presc==PRESC_MAX: presc<=0, count<=count-1, tick next cycle.
//    On that edge with count==1: count<=0, state<=DONE.
//    pause=1 -> PAUSE (presc/count frozen, no decrement on that edge).
//    start=1 -> reload load_val, presc<=0, stay RUN.
//  PAUSE: hold all; pause=0 -> RUN, resuming from the frozen presc. start -> reload and RUN.
//  DONE: exactly one cycle, done=1.
//    periodic=1 -> count<=load_val, presc<=0, RUN (0 reload -> DONE again).
//    periodic=0 -> IDLE with count_out held at 0.
//  stop in any state -> IDLE next cycle; count/presc hold their values; no done/tick pulse.
//  Arithmetic: count never underflows (the 0 transition goes to DONE); presc wraps only at PRESC_MAX.
//  Timing: start accepted at edge E -> RUN from E+1; done high in cycle E + load_val*(PRESC_MAX+1) + 1.
//    Periodic period = load_val*(PRESC_MAX+1)+1 cycles.
// CONFIGURATION
//  TIMER_CTRL_IRQ_STICKY_EN defined: adds ports irq (out,1) and irq_clr (in,1).
//    irq sets on entry to DONE and holds until irq_clr or rst.
//    If set and clear land in the same cycle, set wins.
//  Not defined: no irq/irq_clr ports; done pulse is the only completion indication.
// STRUCTURE
//  timer_ctrl_pkg: state encoding constants (IDLE/RUN/PAUSE/DONE), default PRESC_MAX/PRESC_W/CNT_W.
//  Sub-module timer_prescale_cnt: presc register with en/clr, terminal flag at PRESC_MAX.
//  FSM and down counter stay in timer_ctrl.
// TESTING
//  T1 reset: rst=1 mid-RUN (count=2) -> next cycle state_o=0, count_out=0, busy=0, done=0, tick=0.
//  T2 one-shot: load_val=3, periodic=0, start 1 cycle at edge E
//     -> ticks at E+14/E+27/E+40 (cycle after each decrement at E+13/E+26/E+39);
//        done=1 only in cycle E+40 (coincides with third tick); then IDLE, count_out=0.
//  T3 periodic: load_val=2, periodic=1 -> done every 27 cycles, busy low only in the DONE cycles,
//     5 periods checked.
//  T4 pause: load_val=2, pause high 10 cycles at presc=5 -> counter frozen; done delayed by exactly 10 cycles.
//  T5 edges: load_val=0 start -> done next cycle. stop+start same edge -> IDLE.
//     start during RUN at count=1 -> reload, no done.
//  T6 IRQ_STICKY_EN build: done sets irq. irq stays 1 for 20 cycles until irq_clr.
//     irq_clr coincident with DONE -> irq stays 1.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg
//   Shared definitions for the cascaded prescaler + down-counter timer:
//   FSM state encoding (also the external state_o encoding) and the
//   default geometry used by timer_ctrl and timer_prescale_cnt.
package timer_ctrl_pkg;

    localparam int unsigned PRESC_W_DEF   = 4;
    localparam int unsigned PRESC_MAX_DEF = 12;
    localparam int unsigned CNT_W_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_prescale_cnt.sv
// timer_prescale_cnt
//   Mod-(PRESC_MAX+1) prescaler register for the timer datapath.
// Ports
//   clk     in   sole clock, posedge
//   rst     in   synchronous active-high reset (prescaler -> 0)
//   en      in   advance the prescaler this edge (wraps to 0 at PRESC_MAX)
//   clr     in   force prescaler to 0 this edge (overrides en)
//   term_o  out  prescaler currently holds PRESC_MAX
module timer_prescale_cnt #(
    parameter int unsigned PRESC_W   = 4,
    parameter int unsigned PRESC_MAX = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic term_o
);

    localparam logic [PRESC_W-1:0] TERM_VAL = PRESC_W'(PRESC_MAX);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    always_comb begin
        term_o = (presc_q == TERM_VAL);
    end

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = term_o ? '0 : presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Sequencer for the cascaded prescaler + down-counter timer. Provides
//   start/stop/pause control, loadable count, one-shot/periodic modes and
//   tick/done pulses. Sole owner of the prescaler and down counter.
// Ports
//   clk, rst   sole clock (posedge); synchronous active-high reset
//   start      load load_val and run (restarts if already running)
//   stop       abort to IDLE, count/prescaler hold
//   pause      level; hold the timer while high
//   periodic   auto-reload at terminal count (sampled in DONE)
//   load_val   initial / reload count
//   count_out  current down-counter value
//   busy       state is RUN or PAUSE
//   tick       1-cycle pulse, cycle after each decrement
//   done       high exactly while in DONE
//   state_o    IDLE=0 RUN=1 PAUSE=2 DONE=3
// Build option TIMER_CTRL_IRQ_STICKY_EN adds
//   irq        sticky completion flag, set after DONE
//   irq_clr    clears irq (a coincident set wins)
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PRESC_W   = PRESC_W_DEF,
    parameter int unsigned PRESC_MAX = PRESC_MAX_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count_out,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [1:0]       state_o
`ifdef TIMER_CTRL_IRQ_STICKY_EN
    ,
    output logic             irq,
    input  logic             irq_clr
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             presc_en, presc_clr, presc_term;

    timer_prescale_cnt #(
        .PRESC_W   (PRESC_W),
        .PRESC_MAX (PRESC_MAX)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .en     (presc_en),
        .clr    (presc_clr),
        .term_o (presc_term)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tick_d    = 1'b0;
        presc_en  = 1'b0;
        presc_clr = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            count_d   = load_val;
            presc_clr = 1'b1;
            state_d   = (load_val == '0) ? ST_DONE : ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                // A PAUSE edge with pause low already counts, so the total
                // delay added equals the number of edges pause was high.
                ST_RUN, ST_PAUSE: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d  = ST_RUN;
                        presc_en = 1'b1;
                        if (presc_term) begin
                            tick_d = 1'b1;
                            if (count_q <= CNT_W'(1)) begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end else begin
                                count_d = count_q - CNT_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (periodic) begin
                        count_d   = load_val;
                        presc_clr = 1'b1;
                        state_d   = (load_val == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        count_out = count_q;
        tick      = tick_q;
        busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        done      = (state_q == ST_DONE);
        state_o   = state_q;
    end

`ifdef TIMER_CTRL_IRQ_STICKY_EN
    logic irq_q, irq_d;

    // Set from the DONE cycle itself, so a clear in that cycle loses.
    always_comb begin
        irq_d = (state_q == ST_DONE) || (irq_q && !irq_clr);
        irq   = irq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, periodic;
    logic [3:0] load_val;
    logic [3:0] count_out;
    logic       busy, tick, done;
    logic [1:0] state_o;
`ifdef TIMER_CTRL_IRQ_STICKY_EN
    logic       irq, irq_clr;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    timer_ctrl #(
        .PRESC_W   (4),
        .PRESC_MAX (12),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .periodic  (periodic),
        .load_val  (load_val),
        .count_out (count_out),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .state_o   (state_o)
`ifdef TIMER_CTRL_IRQ_STICKY_EN
        ,
        .irq       (irq),
        .irq_clr   (irq_clr)
`endif
    );

    typedef struct {
        logic        start, stop, pause, periodic;
        logic [3:0]  load;
        int unsigned n;
        logic [1:0]  st;
        logic [3:0]  cnt;
        logic        busy, tick, done;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic p, input logic pa,
                                input logic per, input logic [3:0] ld,
                                input int unsigned n, input logic [1:0] st,
                                input logic [3:0] cnt, input logic b,
                                input logic t, input logic d);
        vec_t v;
        v.start = s; v.stop = p; v.pause = pa; v.periodic = per; v.load = ld;
        v.n = n; v.st = st; v.cnt = cnt; v.busy = b; v.tick = t; v.done = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [8:0] outs();
        return {state_o, count_out, busy, tick, done};
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0;
        load_val = '0;
`ifdef TIMER_CTRL_IRQ_STICKY_EN
        irq_clr = 1'b0;
`endif
        step(2);
        chk("reset_state", 32'(outs()), 32'h0);
        rst = 1'b0;

        //            st pa ps per ld   n  state cnt busy tick done
        vecs[0]  = mk(0, 0, 0, 0, 4'd0, 1,  2'd0, 4'd0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 4'd3, 1,  2'd1, 4'd3, 1, 0, 0); // edge E
        vecs[2]  = mk(0, 0, 0, 0, 4'd3, 12, 2'd1, 4'd3, 1, 0, 0); // E+12
        vecs[3]  = mk(0, 0, 0, 0, 4'd3, 1,  2'd1, 4'd2, 1, 1, 0); // E+13 dec
        vecs[4]  = mk(0, 0, 0, 0, 4'd3, 1,  2'd1, 4'd2, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 4'd3, 12, 2'd1, 4'd1, 1, 1, 0); // E+26 dec
        vecs[6]  = mk(0, 0, 0, 0, 4'd3, 12, 2'd1, 4'd1, 1, 0, 0); // E+38
        vecs[7]  = mk(0, 0, 0, 0, 4'd3, 1,  2'd3, 4'd0, 0, 1, 1); // E+39 done+tick
        vecs[8]  = mk(0, 0, 0, 0, 4'd3, 1,  2'd0, 4'd0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 4'd3, 5,  2'd0, 4'd0, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 4'd0, 1,  2'd3, 4'd0, 0, 0, 1); // zero load
        vecs[11] = mk(0, 0, 0, 0, 4'd0, 1,  2'd0, 4'd0, 0, 0, 0);
        vecs[12] = mk(1, 1, 0, 0, 4'd5, 1,  2'd0, 4'd0, 0, 0, 0); // stop wins
        vecs[13] = mk(1, 0, 0, 0, 4'd1, 1,  2'd1, 4'd1, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 4'd1, 12, 2'd1, 4'd1, 1, 0, 0); // presc at max
        vecs[15] = mk(1, 0, 0, 0, 4'd2, 1,  2'd1, 4'd2, 1, 0, 0); // reload, no done
        vecs[16] = mk(0, 0, 0, 0, 4'd2, 1,  2'd1, 4'd2, 1, 0, 0);
        vecs[17] = mk(0, 1, 0, 0, 4'd2, 1,  2'd0, 4'd2, 0, 0, 0); // stop holds count
        vecs[18] = mk(0, 0, 0, 0, 4'd2, 3,  2'd0, 4'd2, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
            periodic = vecs[i].periodic; load_val = vecs[i].load;
            step(vecs[i].n);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].st, vecs[i].cnt, vecs[i].busy, vecs[i].tick, vecs[i].done}));
        end
        start = 0; stop = 0; pause = 0; periodic = 0;

        // Reset mid-RUN with count=2
        load_val = 4'd3; start = 1; step(1); start = 0;
        step(13);
        chk("t1_pre_count", 32'(count_out), 32'd2);
        rst = 1; step(1);
        chk("t1_reset", 32'(outs()), 32'h0);
        rst = 0;

        // Periodic, load 2: done every 27 cycles, busy low only then
        load_val = 4'd2; periodic = 1; start = 1; step(1); start = 0;
        for (int k = 1; k <= 135; k++) begin
            logic ed;
            step(1);
            ed = (k >= 26) && (((k - 26) % 27) == 0);
            chk($sformatf("t3_k%0d", k), 32'({busy, done}), 32'({~ed, ed}));
        end
        periodic = 0; stop = 1; step(1); stop = 0;
        chk("t3_stopped", 32'(state_o), 32'd0);

        // Pause 10 edges at presc=5: done moves from E+26 to E+36
        begin
            int unsigned seen;
            seen = 0;
            load_val = 4'd2; start = 1; step(1); start = 0;
            step(5);
            pause = 1; step(10);
            chk("t4_paused", 32'({state_o, count_out}), 32'({2'd2, 4'd2}));
            pause = 0;
            for (int k = 16; k <= 60 && seen == 0; k++) begin
                step(1);
                if (done) seen = k;
            end
            chk("t4_done_edge", seen, 32'd36);
            step(1);
            chk("t4_idle", 32'({state_o, count_out}), 32'h0);
        end

`ifdef TIMER_CTRL_IRQ_STICKY_EN
        load_val = 4'd1; start = 1; step(1); start = 0;
        step(13);
        chk("t6_done", 32'(done), 32'd1);
        step(1);
        chk("t6_irq_set", 32'(irq), 32'd1);
        step(20);
        chk("t6_irq_hold", 32'(irq), 32'd1);
        irq_clr = 1; step(1); irq_clr = 0;
        chk("t6_irq_clr", 32'(irq), 32'd0);
        start = 1; step(1); start = 0;
        step(13);
        irq_clr = 1; step(1); irq_clr = 0;
        chk("t6_set_wins", 32'(irq), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
